plru_victim_sel: RTL and testbench
==================================

# plru_victim_sel

Per-set 16-way tree-PLRU state store and victim selector for the data cache. Holds one 15-bit PLRU tree per set, applies MRU updates on every hit or fill ("touch"), and answers victim requests from the miss path with a registered valid/ready response. It is the read side of the PLRU tree: touches move the tree toward a way, victim selection walks the tree to the least-recently-used leaf.

## Interface
- S_INDEX, 4: set-index width; 2^S_INDEX sets stored.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- touch_valid  in  1  apply an MRU update this cycle.
- touch_set  in  S_INDEX  set being touched.
- touch_way  in  4  way being touched (hit way or filled way).
- flush  in  1  synchronous clear of every tree to 15'h0000.
- req_valid  in  1  victim request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_set  in  S_INDEX  set for the victim request.
- valid_mask  in  16  per-way line-valid bits of req_set, sampled with the request.
- rsp_valid  out  1  victim result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_way  out  4  selected victim way.

## Operation
- Tree encoding: bit 0 = root; node n has children 2n+1 (lower ways) and 2n+2 (upper ways); leaf nodes 7..14 each cover a way pair.
- Touch of way w: along w's path, node at level k (root k=0) is written with ~w[3-k]; all other bits kept. Example: touch way 0 sets bits 0,1,3,7 to 1.
- Victim walk: n=0; for k=0..3: rsp_way[3-k]=tree[n]; n=2n+1+tree[n]. Victim selection never modifies the tree; the cache touches the way after fill.
- States: IDLE (rsp_valid=0) and HOLD (rsp_valid=1). IDLE->HOLD on accepted request. HOLD->IDLE on rsp_ready without a new request; HOLD->HOLD on rsp_ready with a new accepted request (back-to-back).
- req_ready = !rsp_valid || rsp_ready.
- Same-cycle touch and accepted request to the same set: victim is computed from the post-touch tree (bypass).
- Touch while in HOLD: tree updated, held rsp_way unchanged.
- flush and touch same cycle: flush wins, touch dropped. flush with accepted request: victim computed from cleared tree (way 0 without macro).
- touch_set/req_set out of range impossible (full index decode).

## Timing
- Reset (asynchronous, rst_n low): all trees 15'h0000, rsp_valid=0, rsp_way=4'd0, req_ready=1.
- Touch: tree write visible to a request in the same cycle (bypass) and stored at the next rising edge.
- Victim latency: request accepted at edge N -> rsp_valid=1 with rsp_way after edge N; held stable until rsp_ready sampled high.
- Throughput: one victim per cycle when rsp_ready held high.
- rst_n asserted mid-HOLD: response dropped, no completion.

## Configuration
- PLRU_INVALID_FIRST_EN defined: if valid_mask != 16'hFFFF at request acceptance, rsp_way = lowest-index way with valid_mask bit 0; otherwise tree walk.
- Undefined: valid_mask ignored; victim is always the tree walk.

## Test plan
- Reset, req set 3 -> rsp_valid one cycle later, rsp_way=0; req_ready=1.
- Touch set 3 way 0, next cycle req set 3 -> tree[3]=15'h008B, rsp_way=8.
- Touch set 5 ways 0..15 in order, then req set 5 -> rsp_way=0; touch way 0 then req -> rsp_way=8.
- Fresh set 2: touch way 0 and req set 2 in same cycle -> rsp_way=8 (bypass).
- rsp_ready low 3 cycles with touch set 3 way 8 meanwhile -> rsp_valid/rsp_way stable, req_ready=0; release -> one handshake, back-to-back req accepted same edge.
- Macro defined: valid_mask 16'hFFF7 -> rsp_way=3; 16'hFFFF on fresh set -> rsp_way=0; undefined: 16'hFFF7 on fresh set -> rsp_way=0.

Source files
------------

// File: rtl/plru_victim_sel_if.sv
// Bus bundle for plru_victim_sel: touch/flush inputs plus the victim request/response handshake.
// The cache side drives through the master modport; the PLRU store is the slave.
interface plru_victim_sel_if #(
  parameter int unsigned SIndex = 4
) ();
  logic              touch_valid;
  logic [SIndex-1:0] touch_set;
  logic [3:0]        touch_way;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [SIndex-1:0] req_set;
  logic [15:0]       valid_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_way;

  modport master (
    output touch_valid, touch_set, touch_way, flush,
    output req_valid, req_set, valid_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_way
  );

  modport slave (
    input  touch_valid, touch_set, touch_way, flush,
    input  req_valid, req_set, valid_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_way
  );
endinterface

// File: rtl/plru_victim_sel.sv
// Per-set 16-way tree-PLRU store with a registered victim-select response.
// Optional PLRU_INVALID_FIRST_EN: prefer the lowest invalid way over the tree walk.
module plru_victim_sel #(
  parameter int unsigned SIndex = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  plru_victim_sel_if.slave  bus
);
  localparam int unsigned NumSets = 1 << SIndex;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e      state_q;
  logic [3:0]  rsp_way_q;
  logic [14:0] tree_q [NumSets];
  logic [14:0] tree_d [NumSets];
  logic [14:0] req_tree;
  logic [3:0]  victim;
  logic        accept;

  // Node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [14:0] apply_touch(logic [14:0] tree, logic [3:0] way);
    logic [3:0] node;
    node = '0;
    for (int k = 0; k < 4; k++) begin
      tree[node] = ~way[3-k];
      node = {node[2:0], 1'b0} + 4'd1 + {3'b000, way[3-k]};
    end
    return tree;
  endfunction

  function automatic logic [3:0] walk_tree(logic [14:0] tree);
    logic [3:0] node;
    logic [3:0] way;
    node = '0;
    way  = '0;
    for (int k = 0; k < 4; k++) begin
      way[3-k] = tree[node];
      node = {node[2:0], 1'b0} + 4'd1 + {3'b000, tree[node]};
    end
    return way;
  endfunction

`ifdef PLRU_INVALID_FIRST_EN
  function automatic logic [3:0] lowest_invalid(logic [15:0] mask);
    logic [3:0] way;
    way = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!mask[i]) way = 4'(i);
    end
    return way;
  endfunction
`endif

  always_comb begin
    for (int s = 0; s < NumSets; s++) tree_d[s] = tree_q[s];
    if (bus.flush) begin
      for (int s = 0; s < NumSets; s++) tree_d[s] = '0;
    end else if (bus.touch_valid) begin
      tree_d[bus.touch_set] = apply_touch(tree_q[bus.touch_set], bus.touch_way);
    end
  end

  // Reading the next-state tree gives the same-cycle touch/flush bypass for free.
  assign req_tree = tree_d[bus.req_set];

`ifdef PLRU_INVALID_FIRST_EN
  assign victim = (bus.valid_mask != 16'hFFFF) ? lowest_invalid(bus.valid_mask)
                                               : walk_tree(req_tree);
`else
  logic unused_valid_mask;
  assign unused_valid_mask = ^bus.valid_mask;
  assign victim = walk_tree(req_tree);
`endif

  assign bus.req_ready = (state_q == StIdle) || bus.rsp_ready;
  assign bus.rsp_valid = (state_q == StHold);
  assign bus.rsp_way   = rsp_way_q;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumSets; s++) tree_q[s] <= '0;
    end else begin
      for (int s = 0; s < NumSets; s++) tree_q[s] <= tree_d[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      rsp_way_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q   <= StHold;
            rsp_way_q <= victim;
          end
        end
        StHold: begin
          if (accept) begin
            rsp_way_q <= victim;
          end else if (bus.rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_plru_victim_sel.sv
// Randomised and directed bench for plru_victim_sel against a heap-indexed PLRU reference model.
module tb_plru_victim_sel;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;

  plru_victim_sel_if #(.SIndex(4)) bus ();

  plru_victim_sel #(.SIndex(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference: level-k node of a path is the heap slot (2^k - 1) + (way prefix of length k).
  logic [14:0] m_tree [16];
  logic        m_valid;
  logic [3:0]  m_way;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) m_tree[s] = '0;
    m_valid = 1'b0;
    m_way   = '0;
  endfunction

  function automatic void model_touch(input int s, input int w);
    for (int k = 0; k < 4; k++) begin
      int idx;
      int bitv;
      idx  = (1 << k) - 1 + (w >> (4 - k));
      bitv = (w >> (3 - k)) & 1;
      m_tree[s][idx] = (bitv == 0);
    end
  endfunction

  function automatic logic [3:0] model_victim(input int s, input logic [15:0] mask);
    int p;
`ifdef PLRU_INVALID_FIRST_EN
    if (mask != 16'hFFFF) begin
      for (int i = 0; i < 16; i++) if (!mask[i]) return 4'(i);
    end
`else
    if (mask == 16'h0) p = 0;
`endif
    p = 0;
    for (int k = 0; k < 4; k++) p = 2 * p + int'(m_tree[s][(1 << k) - 1 + p]);
    return 4'(p);
  endfunction

  task automatic drive_idle();
    bus.touch_valid = 1'b0;
    bus.touch_set   = '0;
    bus.touch_way   = '0;
    bus.flush       = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_set     = '0;
    bus.valid_mask  = 16'hFFFF;
    bus.rsp_ready   = 1'b1;
  endtask

  // One clock: check req_ready, advance the model with the current inputs, check the outputs.
  task automatic step();
    logic       exp_rdy;
    logic       acc;
    logic [3:0] vic;
    #1;
    exp_rdy = !m_valid || bus.rsp_ready;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = bus.req_valid && exp_rdy;
    if (bus.flush) begin
      for (int s = 0; s < 16; s++) m_tree[s] = '0;
    end else if (bus.touch_valid) begin
      model_touch(int'(bus.touch_set), int'(bus.touch_way));
    end
    vic = model_victim(int'(bus.req_set), bus.valid_mask);
    if (acc) begin
      m_valid = 1'b1;
      m_way   = vic;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk_i);
    #1;
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    if (m_valid) check_eq("rsp_way", 32'(bus.rsp_way), 32'(m_way));
    drive_idle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    #12;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    drive_idle();
    do_reset();
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_way", 32'(bus.rsp_way), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);

    bus.req_valid = 1'b1; bus.req_set = 4'd3; step();
    check_eq("fresh_victim", 32'(bus.rsp_way), 32'd0);
    step();

    bus.touch_valid = 1'b1; bus.touch_set = 4'd3; bus.touch_way = 4'd0; step();
    bus.req_valid = 1'b1; bus.req_set = 4'd3; step();
    check_eq("touch0_victim", 32'(bus.rsp_way), 32'd8);
    step();

    for (int w = 0; w < 16; w++) begin
      bus.touch_valid = 1'b1; bus.touch_set = 4'd5; bus.touch_way = 4'(w); step();
    end
    bus.req_valid = 1'b1; bus.req_set = 4'd5; step();
    check_eq("all_touch_victim", 32'(bus.rsp_way), 32'd0);
    bus.touch_valid = 1'b1; bus.touch_set = 4'd5; bus.touch_way = 4'd0; step();
    bus.req_valid = 1'b1; bus.req_set = 4'd5; step();
    check_eq("retouch0_victim", 32'(bus.rsp_way), 32'd8);
    step();

    bus.touch_valid = 1'b1; bus.touch_set = 4'd2; bus.touch_way = 4'd0;
    bus.req_valid = 1'b1; bus.req_set = 4'd2; step();
    check_eq("bypass_victim", 32'(bus.rsp_way), 32'd8);
    step();

    // Stall: held response must not move while set 3 is touched underneath it.
    bus.req_valid = 1'b1; bus.req_set = 4'd7; bus.rsp_ready = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      bus.touch_valid = (i == 0); bus.touch_set = 4'd3; bus.touch_way = 4'd8;
      bus.req_valid = 1'b1; bus.req_set = 4'd3; bus.rsp_ready = 1'b0; step();
      check_eq("stall_way", 32'(bus.rsp_way), 32'd0);
    end
    bus.req_valid = 1'b1; bus.req_set = 4'd3; bus.rsp_ready = 1'b1; step();
    check_eq("b2b_victim", 32'(bus.rsp_way), 32'd4);
    step();

    bus.req_valid = 1'b1; bus.req_set = 4'd9; bus.valid_mask = 16'hFFF7; step();
`ifdef PLRU_INVALID_FIRST_EN
    check_eq("mask_victim", 32'(bus.rsp_way), 32'd3);
`else
    check_eq("mask_victim", 32'(bus.rsp_way), 32'd0);
`endif
    bus.req_valid = 1'b1; bus.req_set = 4'd10; bus.valid_mask = 16'hFFFF; step();
    check_eq("full_mask_victim", 32'(bus.rsp_way), 32'd0);

    bus.flush = 1'b1; bus.touch_valid = 1'b1; bus.touch_set = 4'd3; bus.touch_way = 4'd0;
    bus.req_valid = 1'b1; bus.req_set = 4'd3; step();
    check_eq("flush_victim", 32'(bus.rsp_way), 32'd0);

    // Reset while holding a response drops it immediately.
    bus.req_valid = 1'b1; bus.req_set = 4'd3; bus.rsp_ready = 1'b0; step();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_eq("midhold_rst", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 3000; i++) begin
      bus.touch_valid = ($urandom_range(0, 1) == 1);
      bus.touch_set   = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15)
                                                     : $urandom_range(0, 2));
      bus.touch_way   = 4'($urandom_range(0, 15));
      bus.flush       = ($urandom_range(0, 63) == 0);
      bus.req_valid   = ($urandom_range(0, 1) == 1);
      bus.req_set     = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15)
                                                     : $urandom_range(0, 2));
      bus.valid_mask  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      bus.rsp_ready   = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
